avalon_filter_3x3_cfg: RTL

// - Parametrised successor to the fixed 3x3 RGB stream filter. It sits between the PCIe DMA

---
 rtl/avalon_filter_3x3_cfg_if.sv | 24 ++
 rtl/avalon_filter_3x3_cfg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_filter_3x3_cfg_if.sv
// Stream bundle for the 3x3 filter: Avalon-ST sink into the filter and Avalon-ST source out of it.
// The filter uses the slave view; whatever feeds and drains it uses the master view.
interface avalon_filter_3x3_cfg_if #(
  parameter int PW = 24
);
  logic [PW-1:0] sinkData;
  logic          sinkValid;
  logic          sinkReady;
  logic [PW-1:0] sourceData;
  logic          sourceValid;
  logic          sourceReady;
  logic          sourceSop;
  logic          sourceEop;

  modport slave (
    input  sinkData, sinkValid, sourceReady,
    output sinkReady, sourceData, sourceValid, sourceSop, sourceEop
  );

  modport master (
    output sinkData, sinkValid, sourceReady,
    input  sinkReady, sourceData, sourceValid, sourceSop, sourceEop
  );
endinterface

// File: rtl/avalon_filter_3x3_cfg.sv
// Raster-order 3x3 stream filter (bypass/gaussian/sharpen/sobel) with per-frame kernel select.
// Two line buffers feed a 3x3 window; the output lags the input by one line plus one pixel.
module avalon_filter_3x3_cfg #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CH    = 3,
  parameter int CW    = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [1:0]             mode_i,
  avalon_filter_3x3_cfg_if.slave bus
);
  localparam int PW    = CH * CW;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int IW    = CW + 4;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(NPIX - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [IW-1:0]    MAXV      = IW'((1 << CW) - 1);
  localparam logic [CW-1:0]    MAXC      = CW'((1 << CW) - 1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    lineBuf0 [IMG_W];
  logic [PW-1:0]    lineBuf1 [IMG_W];
  logic [PW-1:0]    win_q [3][3];
  logic [PW-1:0]    win_d [3][3];
  logic [CNT_W-1:0] inCnt_q;
  logic [COL_W-1:0] inCol_q;
  logic [COL_W-1:0] outCol_q;
  logic [ROW_W-1:0] outRow_q;
  logic [1:0]       mode_q;
  logic             readyEn_q;
  logic             done_q;
  logic [PW-1:0]    srcData_q;
  logic             srcValid_q;
  logic             srcSop_q;
  logic             srcEop_q;

  logic             sinkReady, sinkXfer, srcXfer, slotFree;
  logic             doShift, doLoad, border, lastOut;
  logic [PW-1:0]    filtered;

  function automatic logic [CW-1:0] filterCh(
    input logic [1:0]    m,
    input logic [CW-1:0] nw, input logic [CW-1:0] n,  input logic [CW-1:0] ne,
    input logic [CW-1:0] w,  input logic [CW-1:0] c,  input logic [CW-1:0] e,
    input logic [CW-1:0] sw, input logic [CW-1:0] s,  input logic [CW-1:0] se
  );
    logic [IW-1:0] gauss, sharp, gx, gy, ax, ay, mag;
    logic [CW-1:0] res;
    // Signed results live in IW-bit two's complement; the sign bit is inspected directly.
    gauss = (IW'(c) << 2) + ((IW'(n) + IW'(s) + IW'(e) + IW'(w)) << 1)
          + IW'(nw) + IW'(ne) + IW'(sw) + IW'(se);
    sharp = (IW'(c) << 2) + IW'(c) - IW'(n) - IW'(s) - IW'(e) - IW'(w);
    gx    = IW'(ne) + (IW'(e) << 1) + IW'(se) - IW'(nw) - (IW'(w) << 1) - IW'(sw);
    gy    = IW'(sw) + (IW'(s) << 1) + IW'(se) - IW'(nw) - (IW'(n) << 1) - IW'(ne);
    ax    = gx[IW-1] ? -gx : gx;
    ay    = gy[IW-1] ? -gy : gy;
    mag   = ax + ay;
    case (m)
      2'd1:    res = CW'(gauss >> 4);
      2'd2:    res = sharp[IW-1] ? '0 : ((sharp > MAXV) ? MAXC : CW'(sharp));
      2'd3:    res = (mag > MAXV) ? MAXC : CW'(mag);
      default: res = c;
    endcase
    return res;
  endfunction

  assign slotFree = !srcValid_q || bus.sourceReady;
  assign srcXfer  = srcValid_q && bus.sourceReady;
  assign border   = (outRow_q == '0) || (outRow_q == ROW_LAST) ||
                    (outCol_q == '0) || (outCol_q == COL_LAST);
  assign lastOut  = (outRow_q == ROW_LAST) && (outCol_q == COL_LAST);

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lineBuf1[inCol_q];
    win_d[1][2] = lineBuf0[inCol_q];
    win_d[2][2] = bus.sinkData;
  end

  // The output register is loaded from the window as it will look after this shift.
  always_comb begin
    filtered = '0;
    for (int ch = 0; ch < CH; ch++) begin
      filtered[ch*CW +: CW] = border ? win_d[1][1][ch*CW +: CW] :
        filterCh(mode_q,
                 win_d[0][0][ch*CW +: CW], win_d[0][1][ch*CW +: CW], win_d[0][2][ch*CW +: CW],
                 win_d[1][0][ch*CW +: CW], win_d[1][1][ch*CW +: CW], win_d[1][2][ch*CW +: CW],
                 win_d[2][0][ch*CW +: CW], win_d[2][1][ch*CW +: CW], win_d[2][2][ch*CW +: CW]);
    end
  end

  always_comb begin
    state_d   = state_q;
    sinkReady = 1'b0;
    sinkXfer  = 1'b0;
    doShift   = 1'b0;
    doLoad    = 1'b0;
    case (state_q)
      FILL: begin
        sinkReady = readyEn_q;
        sinkXfer  = bus.sinkValid && sinkReady;
        doShift   = sinkXfer;
        if (sinkXfer && inCnt_q == FILL_LAST) state_d = RUN;
      end
      RUN: begin
        sinkReady = readyEn_q && slotFree;
        sinkXfer  = bus.sinkValid && sinkReady;
        doShift   = sinkXfer;
        doLoad    = sinkXfer;
        if (sinkXfer && inCnt_q == RUN_LAST) state_d = FLUSH;
      end
      FLUSH: begin
        // The remaining outputs are all border pixels, so the window shifts without new data.
        doShift = slotFree && !done_q;
        doLoad  = doShift;
        if (srcXfer && srcEop_q) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= FILL;
      inCnt_q    <= '0;
      inCol_q    <= '0;
      outRow_q   <= '0;
      outCol_q   <= '0;
      mode_q     <= 2'd0;
      readyEn_q  <= 1'b0;
      done_q     <= 1'b0;
      srcData_q  <= '0;
      srcValid_q <= 1'b0;
      srcSop_q   <= 1'b0;
      srcEop_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      readyEn_q <= 1'b1;
      if (sinkXfer) inCnt_q <= inCnt_q + 1'b1;
      if (sinkXfer && state_q == FILL && inCnt_q == '0) mode_q <= mode_i;
      if (doShift) inCol_q <= (inCol_q == COL_LAST) ? '0 : inCol_q + 1'b1;
      if (doLoad) begin
        srcData_q  <= filtered;
        srcValid_q <= 1'b1;
        srcSop_q   <= (outRow_q == '0) && (outCol_q == '0);
        srcEop_q   <= lastOut;
        if (lastOut) done_q <= 1'b1;
        if (outCol_q == COL_LAST) begin
          outCol_q <= '0;
          outRow_q <= outRow_q + 1'b1;
        end else begin
          outCol_q <= outCol_q + 1'b1;
        end
      end else if (bus.sourceReady) begin
        srcValid_q <= 1'b0;
        srcSop_q   <= 1'b0;
        srcEop_q   <= 1'b0;
      end
      if (state_q == FLUSH && state_d == FILL) begin
        inCnt_q  <= '0;
        inCol_q  <= '0;
        outRow_q <= '0;
        outCol_q <= '0;
        done_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (doShift) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= win_d[r][c];
    end
    if (sinkXfer) begin
      lineBuf1[inCol_q] <= lineBuf0[inCol_q];
      lineBuf0[inCol_q] <= bus.sinkData;
    end
  end

  assign bus.sinkReady   = sinkReady;
  assign bus.sourceData  = srcData_q;
  assign bus.sourceValid = srcValid_q;
  assign bus.sourceSop   = srcSop_q;
  assign bus.sourceEop   = srcEop_q;
endmodule
